// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD time base (00:00..59:59) under an IDLE/RUN/PAUSE control FSM.
// Latency: digits, running and wrap are registered; each is visible the cycle after its pulse is sampled.
// Backpressure: none; every tick/start_stop/clear/lap pulse is consumed in the cycle it is sampled.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  count-enable pulse, +1 s while in RUN
//   start_stop            toggles RUN/PAUSE (IDLE -> RUN)
//   clear                 zeroes the count, returns to IDLE, drops lap hold
//   lap                   toggles lap hold (only with STOPWATCH_LAP_EN)
//   sec_ones..min_tens    displayed BCD digits
//   running               high in RUN
//   wrap                  one-cycle pulse when 59:59 rolls to 00:00
//   lap_active            high while the displayed digits are frozen
// Optional feature macro: STOPWATCH_LAP_EN builds the lap-hold display registers.
module stopwatch_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap,
  output logic       lap_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] so_q, st_q, mo_q, mt_q;
  logic [3:0] so_d, st_d, mo_d, mt_d;
  logic       wrap_q, wrap_d;
  logic       c0, c1, c2, c3;

  // Next state and BCD ripple increment. The tick is qualified by the
  // current state, so a start_stop+tick in RUN still counts the tick, while
  // the same pair in PAUSE only resumes. clear overrides everything.
  always_comb begin
    state_d = state_q;
    so_d    = so_q;
    st_d    = st_q;
    mo_d    = mo_q;
    mt_d    = mt_q;
    wrap_d  = 1'b0;
    c0      = (state_q == RUN) && tick;
    c1      = 1'b0;
    c2      = 1'b0;
    c3      = 1'b0;

    // ">=" on the limits keeps a digit recoverable even if it were ever
    // corrupted to an out-of-range value.
    if (c0) begin
      if (so_q >= 4'd9) begin
        so_d = 4'd0;
        c1   = 1'b1;
      end else begin
        so_d = so_q + 4'd1;
      end
    end
    if (c1) begin
      if (st_q >= 4'd5) begin
        st_d = 4'd0;
        c2   = 1'b1;
      end else begin
        st_d = st_q + 4'd1;
      end
    end
    if (c2) begin
      if (mo_q >= 4'd9) begin
        mo_d = 4'd0;
        c3   = 1'b1;
      end else begin
        mo_d = mo_q + 4'd1;
      end
    end
    if (c3) begin
      if (mt_q >= 4'd5) begin
        mt_d   = 4'd0;
        wrap_d = 1'b1;
      end else begin
        mt_d = mt_q + 4'd1;
      end
    end

    case (state_q)
      IDLE:    if (start_stop) state_d = RUN;
      RUN:     if (start_stop) state_d = PAUSE;
      PAUSE:   if (start_stop) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      so_d    = 4'd0;
      st_d    = 4'd0;
      mo_d    = 4'd0;
      mt_d    = 4'd0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      so_q    <= 4'd0;
      st_q    <= 4'd0;
      mo_q    <= 4'd0;
      mt_q    <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      so_q    <= so_d;
      st_q    <= st_d;
      mo_q    <= mo_d;
      mt_q    <= mt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign running = (state_q == RUN);
  assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic       lap_q;
  logic [3:0] so_h, st_h, mo_h, mt_h;

  // Hold registers capture the live count on the first lap pulse; the
  // second pulse releases the mux so the live count shows immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q <= 1'b0;
      so_h  <= 4'd0;
      st_h  <= 4'd0;
      mo_h  <= 4'd0;
      mt_h  <= 4'd0;
    end else if (clear) begin
      lap_q <= 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      lap_q <= ~lap_q;
      if (!lap_q) begin
        so_h <= so_q;
        st_h <= st_q;
        mo_h <= mo_q;
        mt_h <= mt_q;
      end
    end
  end

  assign lap_active = lap_q;
  assign sec_ones   = lap_q ? so_h : so_q;
  assign sec_tens   = lap_q ? st_h : st_q;
  assign min_ones   = lap_q ? mo_h : mo_q;
  assign min_tens   = lap_q ? mt_h : mt_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign sec_ones   = so_q;
  assign sec_tens   = st_q;
  assign min_ones   = mo_q;
  assign min_tens   = mt_q;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: table-driven vectors plus scoreboard checking of stopwatch_counter.
// Expected outputs come from a seconds-count model converted to BCD by division.
`timescale 1ns/1ps
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, wrap, lap_active;

  stopwatch_counter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .wrap       (wrap),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  int checks = 0;
  int errors = 0;

  // Reference model: plain seconds count 0..3599
  int  m_cnt   = 0;
  int  m_disp  = 0;
  int  m_state = S_IDLE;
  bit  m_lap   = 1'b0;
  bit  m_wrap  = 1'b0;
  logic [18:0] exp_q[$];

  typedef struct {
    bit t;
    bit ss;
    bit c;
    bit l;
    int reps;
    int sec;
    bit run;
    bit lp;
  } vec_t;
  vec_t tbl[22];

  function automatic logic [18:0] pack_exp(int s, bit r, bit w, bit l);
    logic [3:0] a, b, c, d;
    a = 4'(s % 10);
    b = 4'((s / 10) % 6);
    c = 4'((s / 60) % 10);
    d = 4'(s / 600);
    return {d, c, b, a, r, w, l};
  endfunction

  function automatic logic [18:0] pack_dut();
    return {min_tens, min_ones, sec_tens, sec_ones, running, wrap, lap_active};
  endfunction

  function automatic string fmt(logic [18:0] v);
    return $sformatf("%0h%0h:%0h%0h run=%0b wrap=%0b lap=%0b",
                     v[18:15], v[14:11], v[10:7], v[6:3], v[2], v[1], v[0]);
  endfunction

  task automatic check(string name, logic [18:0] got, logic [18:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(want));
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_disp  = 0;
    m_state = S_IDLE;
    m_lap   = 1'b0;
    m_wrap  = 1'b0;
  endtask

  task automatic model_step(bit t, bit ss, bit c, bit l);
    if (c) begin
      m_cnt   = 0;
      m_state = S_IDLE;
      m_wrap  = 1'b0;
      m_lap   = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (LAP && l && m_state != S_IDLE) begin
        if (!m_lap) begin
          m_lap  = 1'b1;
          m_disp = m_cnt;
        end else begin
          m_lap = 1'b0;
        end
      end
      if (m_state == S_RUN && t) begin
        m_cnt++;
        if (m_cnt == 3600) begin
          m_cnt  = 0;
          m_wrap = 1'b1;
        end
      end
      if (ss) m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN;
    end
    exp_q.push_back(pack_exp(m_lap ? m_disp : m_cnt, m_state == S_RUN, m_wrap, m_lap));
  endtask

  // One clock: drive at the falling edge, push the expectation, compare 1 ns after the rising edge.
  task automatic cycle(bit t, bit ss, bit c, bit l);
    logic [18:0] want;
    @(negedge clk);
    tick       = t;
    start_stop = ss;
    clear      = c;
    lap        = l;
    model_step(t, ss, c, l);
    @(posedge clk);
    #1;
    tick       = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued, got %s", fmt(pack_dut()));
    end else begin
      want = exp_q.pop_front();
      check("scoreboard", pack_dut(), want);
    end
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 10, 0, 0, 0};            // ticks ignored in IDLE
    tbl[1]  = '{0, 1, 0, 0, 1,  0, 1, 0};            // start
    tbl[2]  = '{1, 0, 0, 0, 61, 61, 1, 0};           // 01:01
    tbl[3]  = '{0, 0, 1, 0, 1,  0, 0, 0};            // clear
    tbl[4]  = '{0, 1, 0, 0, 1,  0, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 5,  5, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 1,  5, 0, 0};            // pause
    tbl[7]  = '{1, 0, 0, 0, 3,  5, 0, 0};            // ticks ignored in PAUSE
    tbl[8]  = '{0, 1, 0, 0, 1,  5, 1, 0};            // resume
    tbl[9]  = '{1, 0, 0, 0, 1,  6, 1, 0};
    tbl[10] = '{1, 1, 0, 0, 1,  7, 0, 0};            // RUN: tick counted, then pause
    tbl[11] = '{1, 1, 0, 0, 1,  7, 1, 0};            // PAUSE: resume, tick dropped
    tbl[12] = '{1, 0, 0, 0, 3,  10, 1, 0};
    tbl[13] = '{0, 0, 0, 1, 1,  10, 1, LAP};         // lap hold
    tbl[14] = '{1, 0, 0, 0, 5,  LAP ? 10 : 15, 1, LAP};
    tbl[15] = '{0, 0, 0, 1, 1,  15, 1, 0};           // release shows live count
    tbl[16] = '{0, 0, 1, 0, 1,  0, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 1,  0, 0, 0};            // lap in IDLE ignored
    tbl[18] = '{0, 1, 0, 0, 1,  0, 1, 0};
    tbl[19] = '{1, 0, 0, 0, 2,  2, 1, 0};
    tbl[20] = '{0, 0, 0, 1, 1,  2, 1, LAP};
    tbl[21] = '{0, 0, 1, 0, 1,  0, 0, 0};            // clear drops lap hold

    // Reset state, checked before the first clock edge
    model_reset();
    #2;
    check("reset", pack_dut(), pack_exp(0, 0, 0, 0));
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      for (int r = 0; r < tbl[i].reps; r++)
        cycle(tbl[i].t, tbl[i].ss, tbl[i].c, tbl[i].l);
      check($sformatf("row%0d", i), pack_dut(), pack_exp(tbl[i].sec, tbl[i].run, 1'b0, tbl[i].lp));
    end

    // Rollover 59:59 -> 00:00 with a single-cycle wrap
    cycle(0, 1, 0, 0);
    repeat (3598) cycle(1, 0, 0, 0);
    check("preload 59:58", pack_dut(), pack_exp(3598, 1, 0, 0));
    cycle(1, 0, 0, 0);
    check("59:59", pack_dut(), pack_exp(3599, 1, 0, 0));
    cycle(1, 0, 0, 0);
    check("wrap to 00:00", pack_dut(), pack_exp(0, 1, 1, 0));
    cycle(0, 0, 0, 0);
    check("wrap one cycle", pack_dut(), pack_exp(0, 1, 0, 0));

    // clear beats tick at 12:34
    repeat (754) cycle(1, 0, 0, 0);
    check("at 12:34", pack_dut(), pack_exp(754, 1, 0, 0));
    cycle(1, 0, 1, 0);
    check("clear with tick", pack_dut(), pack_exp(0, 0, 0, 0));

    // start_stop held high toggles every cycle
    repeat (4) cycle(0, 1, 0, 0);
    check("held start_stop", pack_dut(), pack_exp(0, 0, 0, 0));
    cycle(0, 1, 0, 0);

    // Asynchronous reset between edges at 03:27
    repeat (207) cycle(1, 0, 0, 0);
    check("at 03:27", pack_dut(), pack_exp(207, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset", pack_dut(), pack_exp(0, 0, 0, 0));
    model_reset();
    #3;
    rst_n = 1'b1;
    repeat (5) cycle(1, 0, 0, 0);
    check("ticks after reset", pack_dut(), pack_exp(0, 0, 0, 0));
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("restart", pack_dut(), pack_exp(1, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
